// File: rtl/trig_acq_receiver_pkg.sv
// Shared definitions for the acquisition trigger path: FSM state encodings and
// trigger source codes used by the receiver and the trigger generators.
package trig_acq_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_READOUT = 2'd2,
        ST_DEAD    = 2'd3
    } trig_state_e;

    localparam logic SRC_INT = 1'b0;
    localparam logic SRC_EXT = 1'b1;

    function automatic logic is_busy_state(input trig_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/trig_acq_receiver_ext_trig_sync.sv
// External trigger conditioner: two-flop synchroniser followed by an edge flop,
// producing one pulse per rising edge of the asynchronous ext_trig level.
module ext_trig_sync (
    input  logic Clk,
    input  logic reset_n,
    input  logic ext_trig,
    output logic ext_pulse
);

    logic sync1_r;
    logic sync2_r;
    logic edge_r;

    // synchroniser chain and previous-value flop for edge detection
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= ext_trig;
            sync2_r <= sync1_r;
            edge_r  <= sync2_r;
        end
    end

    assign ext_pulse = sync2_r & ~edge_r;

endmodule

// File: rtl/trig_acq_receiver.sv
// Consumer end of the acquisition trigger path: accepts a trigger, runs the
// delay / hold+readout / dead-time sequence and keeps trigger statistics.
module trig_acq_receiver
    import trig_acq_receiver_pkg::*;
#(
    parameter int DELAY_W     = 8,
    parameter int DEAD_CYCLES = 16,
    parameter int CNT_W       = 32,
    parameter int LOST_W      = 16
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               trig_en_i,
    input  logic               ext_trig,
    input  logic               trig_sel,
    input  logic               acq_enable,
    input  logic [DELAY_W-1:0] hold_delay,
    input  logic               readout_done,
    input  logic               clr_counters,
    output logic               hold_out,
    output logic               readout_req,
    output logic               busy,
    output logic [CNT_W-1:0]   trig_count,
    output logic [LOST_W-1:0]  lost_count
);

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0]  DEAD_LOAD = DEAD_W'((DEAD_CYCLES > 0) ? (DEAD_CYCLES - 1) : 0);
    localparam logic [DEAD_W-1:0]  DEAD_ONE  = DEAD_W'(1);
    localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [LOST_W-1:0]  LOST_ONE  = LOST_W'(1);
    localparam logic [LOST_W-1:0]  LOST_MAX  = {LOST_W{1'b1}};

    trig_state_e        state_r;
    trig_state_e        state_nxt_s;
    logic [DELAY_W-1:0] delay_cnt_r;
    logic [DELAY_W-1:0] delay_cnt_nxt_s;
    logic [DEAD_W-1:0]  dead_cnt_r;
    logic [DEAD_W-1:0]  dead_cnt_nxt_s;
    logic               ext_pulse_s;
    logic               trig_p_s;
    logic               accept_s;
    logic               lost_s;
    logic               leave_readout_s;
    logic               hold_out_r;
    logic               readout_req_r;
    logic               busy_r;
    logic [CNT_W-1:0]   trig_count_r;
    logic [LOST_W-1:0]  lost_count_r;

    ext_trig_sync u_ext_trig_sync (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .ext_trig  (ext_trig),
        .ext_pulse (ext_pulse_s)
    );

    assign trig_p_s = (trig_sel == SRC_EXT) ? ext_pulse_s : trig_en_i;
    assign accept_s = trig_p_s & acq_enable & (state_r == ST_IDLE);
    assign lost_s   = trig_p_s & acq_enable & (state_r != ST_IDLE);
    // done only counts once the request is actually visible to the controller
    assign leave_readout_s = (state_r == ST_READOUT) & readout_done & readout_req_r;

    // next-state and counter-load logic
    always_comb begin
        state_nxt_s     = state_r;
        delay_cnt_nxt_s = delay_cnt_r;
        dead_cnt_nxt_s  = dead_cnt_r;
        if (!acq_enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (hold_delay == {DELAY_W{1'b0}}) begin
                            state_nxt_s = ST_READOUT;
                        end else begin
                            state_nxt_s     = ST_DELAY;
                            delay_cnt_nxt_s = hold_delay - DELAY_ONE;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_r == {DELAY_W{1'b0}}) begin
                        state_nxt_s = ST_READOUT;
                    end else begin
                        delay_cnt_nxt_s = delay_cnt_r - DELAY_ONE;
                    end
                end
                ST_READOUT: begin
                    if (leave_readout_s) begin
                        if (DEAD_CYCLES == 0) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s    = ST_DEAD;
                            dead_cnt_nxt_s = DEAD_LOAD;
                        end
                    end else begin
                        state_nxt_s = ST_READOUT;
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_r == {DEAD_W{1'b0}}) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        dead_cnt_nxt_s = dead_cnt_r - DEAD_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // state and sequence counters
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            delay_cnt_r <= {DELAY_W{1'b0}};
            dead_cnt_r  <= {DEAD_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            delay_cnt_r <= delay_cnt_nxt_s;
            dead_cnt_r  <= dead_cnt_nxt_s;
        end
    end

    // registered handshake outputs; hold rises one cycle after READOUT is entered
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_out_r    <= 1'b0;
            readout_req_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            hold_out_r    <= acq_enable & (state_r == ST_READOUT) & ~leave_readout_s;
            readout_req_r <= acq_enable & (state_r == ST_READOUT) & ~leave_readout_s;
            busy_r        <= is_busy_state(state_nxt_s);
        end
    end

    // trigger statistics: accepted count wraps, lost count saturates
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_count_r <= {CNT_W{1'b0}};
            lost_count_r <= {LOST_W{1'b0}};
        end else if (clr_counters) begin
            trig_count_r <= {CNT_W{1'b0}};
            lost_count_r <= {LOST_W{1'b0}};
        end else begin
            if (accept_s) begin
                trig_count_r <= trig_count_r + CNT_ONE;
            end
            if (lost_s && (lost_count_r != LOST_MAX)) begin
                lost_count_r <= lost_count_r + LOST_ONE;
            end
        end
    end

    assign hold_out    = hold_out_r;
    assign readout_req = readout_req_r;
    assign busy        = busy_r;
    assign trig_count  = trig_count_r;
    assign lost_count  = lost_count_r;

endmodule

// File: tb/tb_trig_acq_receiver.sv
// Bench for trig_acq_receiver: two builds (16-cycle dead time with narrow counters,
// and no dead time) driven together and checked against a timestamp-based model.
module tb_trig_acq_receiver;

    logic        Clk;
    logic        reset_n;
    logic        trig_en_i;
    logic        ext_trig;
    logic        trig_sel;
    logic        acq_enable;
    logic [7:0]  hold_delay;
    logic        readout_done;
    logic        clr_counters;

    logic        d0_hold, d0_req, d0_busy;
    logic [3:0]  d0_tc;
    logic [2:0]  d0_lc;
    logic        d1_hold, d1_req, d1_busy;
    logic [31:0] d1_tc;
    logic [15:0] d1_lc;

    int n_cmp = 0;
    int n_bad = 0;
    logic run_cmp = 1'b0;

    trig_acq_receiver #(.DELAY_W(8), .DEAD_CYCLES(16), .CNT_W(4), .LOST_W(3)) dut0 (
        .Clk(Clk), .reset_n(reset_n), .trig_en_i(trig_en_i), .ext_trig(ext_trig),
        .trig_sel(trig_sel), .acq_enable(acq_enable), .hold_delay(hold_delay),
        .readout_done(readout_done), .clr_counters(clr_counters),
        .hold_out(d0_hold), .readout_req(d0_req), .busy(d0_busy),
        .trig_count(d0_tc), .lost_count(d0_lc)
    );

    trig_acq_receiver #(.DELAY_W(8), .DEAD_CYCLES(0), .CNT_W(32), .LOST_W(16)) dut1 (
        .Clk(Clk), .reset_n(reset_n), .trig_en_i(trig_en_i), .ext_trig(ext_trig),
        .trig_sel(trig_sel), .acq_enable(acq_enable), .hold_delay(hold_delay),
        .readout_done(readout_done), .clr_counters(clr_counters),
        .hold_out(d1_hold), .readout_req(d1_req), .busy(d1_busy),
        .trig_count(d1_tc), .lost_count(d1_lc)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- model: sequence described by event timestamps ----------------
    int          cyc;
    logic        h1, h2, h3;
    logic        m_act  [2];
    logic        m_hold [2];
    logic        m_dead [2];
    int          m_hold_at  [2];
    int          m_dead_end [2];
    logic [31:0] m_tc [2];
    logic [31:0] m_lc [2];
    int          dead_c [2];
    logic [31:0] cmask  [2];
    logic [31:0] lmax   [2];

    task automatic model_clear();
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_hold[i] = 1'b0; m_dead[i] = 1'b0;
            m_hold_at[i] = 0; m_dead_end[i] = 0;
            m_tc[i] = 32'd0; m_lc[i] = 32'd0;
        end
    endtask

    initial begin : model
        logic tp;
        dead_c[0] = 16;           dead_c[1] = 0;
        cmask[0]  = 32'h0000000F; cmask[1]  = 32'hFFFFFFFF;
        lmax[0]   = 32'h00000007; lmax[1]   = 32'h0000FFFF;
        cyc = 0;
        model_clear();
        forever begin
            @(posedge Clk or negedge reset_n);
            if (!reset_n) begin
                model_clear();
            end else begin
                cyc++;
                // external pulse seen at edge e: level sampled high at e-2, low at e-3
                tp = trig_sel ? (h2 & ~h3) : trig_en_i;
                for (int i = 0; i < 2; i++) begin
                    if (!acq_enable) begin
                        m_act[i] = 1'b0; m_hold[i] = 1'b0; m_dead[i] = 1'b0;
                    end else if (m_act[i]) begin
                        if (tp && (m_lc[i] != lmax[i])) m_lc[i] = m_lc[i] + 32'd1;
                        if (m_hold[i] && readout_done) begin
                            m_hold[i] = 1'b0;
                            if (dead_c[i] == 0) m_act[i] = 1'b0;
                            else begin m_dead[i] = 1'b1; m_dead_end[i] = cyc + dead_c[i]; end
                        end else if (!m_hold[i] && !m_dead[i] && (cyc == m_hold_at[i])) begin
                            m_hold[i] = 1'b1;
                        end else if (m_dead[i] && (cyc == m_dead_end[i])) begin
                            m_act[i] = 1'b0; m_dead[i] = 1'b0;
                        end
                    end else if (tp) begin
                        m_tc[i] = (m_tc[i] + 32'd1) & cmask[i];
                        m_act[i] = 1'b1; m_hold[i] = 1'b0; m_dead[i] = 1'b0;
                        m_hold_at[i] = cyc + 1 + int'(hold_delay);
                    end
                    if (clr_counters) begin m_tc[i] = 32'd0; m_lc[i] = 32'd0; end
                end
                h3 = h2; h2 = h1; h1 = ext_trig;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge Clk);
            if (run_cmp) begin
                chk("d0_hold", {31'd0, d0_hold}, {31'd0, m_hold[0]});
                chk("d0_req",  {31'd0, d0_req},  {31'd0, m_hold[0]});
                chk("d0_busy", {31'd0, d0_busy}, {31'd0, m_act[0]});
                chk("d0_tc",   {28'd0, d0_tc},   m_tc[0]);
                chk("d0_lc",   {29'd0, d0_lc},   m_lc[0]);
                chk("d1_hold", {31'd0, d1_hold}, {31'd0, m_hold[1]});
                chk("d1_req",  {31'd0, d1_req},  {31'd0, m_hold[1]});
                chk("d1_busy", {31'd0, d1_busy}, {31'd0, m_act[1]});
                chk("d1_tc",   d1_tc,            m_tc[1]);
                chk("d1_lc",   {16'd0, d1_lc},   m_lc[1]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic pulse_trig();
        trig_en_i = 1'b1;
        tick(1);
        trig_en_i = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; trig_en_i = 1'b0; ext_trig = 1'b0; trig_sel = 1'b0;
        acq_enable = 1'b1; hold_delay = 8'd3; readout_done = 1'b0; clr_counters = 1'b0;
        #1;
        chk("rst_hold", {31'd0, d0_hold}, 32'd0);
        chk("rst_req",  {31'd0, d0_req},  32'd0);
        chk("rst_busy", {31'd0, d0_busy}, 32'd0);
        chk("rst_tc",   {28'd0, d0_tc},   32'd0);
        chk("rst_lc",   {29'd0, d0_lc},   32'd0);
        tick(3);
        reset_n = 1'b1;
        run_cmp = 1'b1;
        tick(2);

        // internal trigger, delay 3; delay change after acceptance has no effect
        pulse_trig();
        hold_delay = 8'd7;
        chk("t1_busy_k", {31'd0, d0_busy}, 32'd1);
        tick(3);
        chk("t1_hold_k3", {31'd0, d0_hold}, 32'd0);
        tick(1);
        chk("t1_hold_k4", {31'd0, d0_hold}, 32'd1);
        chk("t1_req_k4",  {31'd0, d0_req},  32'd1);
        tick(5);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        chk("t1_hold_drop", {31'd0, d0_hold}, 32'd0);
        chk("t1_req_drop",  {31'd0, d0_req},  32'd0);
        chk("t1_busy_dead", {31'd0, d0_busy}, 32'd1);
        chk("t1_d1_busy",   {31'd0, d1_busy}, 32'd0);
        tick(15);
        chk("t1_busy_15", {31'd0, d0_busy}, 32'd1);
        tick(1);
        chk("t1_busy_16", {31'd0, d0_busy}, 32'd0);
        chk("t1_tc",      {28'd0, d0_tc},   32'd1);

        // zero delay
        hold_delay = 8'd0;
        pulse_trig();
        chk("t2_hold_k", {31'd0, d0_hold}, 32'd0);
        tick(1);
        chk("t2_hold_k1", {31'd0, d0_hold}, 32'd1);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        tick(18);

        // external trigger held high ~21 cycles, arbitrary phase
        trig_sel = 1'b1;
        hold_delay = 8'd2;
        #($urandom_range(0, 5));
        ext_trig = 1'b1;
        tick(5);
        chk("t3_hold_5", {31'd0, d0_hold}, 32'd0);
        tick(1);
        chk("t3_hold_6", {31'd0, d0_hold}, 32'd1);
        pulse_trig();
        tick(13);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        ext_trig = 1'b0;
        tick(18);
        chk("t3_tc", {28'd0, d0_tc}, 32'd3);
        chk("t3_lc", {29'd0, d0_lc}, 32'd0);

        // lost triggers during READOUT and DEAD, then saturation
        trig_sel = 1'b0;
        hold_delay = 8'd0;
        pulse_trig();
        tick(1);
        repeat (3) begin pulse_trig(); tick(1); end
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        repeat (2) begin pulse_trig(); tick(1); end
        chk("t4_lc5", {29'd0, d0_lc}, 32'd5);
        chk("t4_tc",  {28'd0, d0_tc}, 32'd4);
        repeat (2) begin pulse_trig(); tick(1); end
        chk("t4_lc7", {29'd0, d0_lc}, 32'd7);
        tick(7);
        pulse_trig();
        chk("t4_lc_sat",   {29'd0, d0_lc},   32'd7);
        chk("t4_busy_end", {31'd0, d0_busy}, 32'd0);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        tick(4);

        // acq_enable abort in DELAY and in READOUT
        hold_delay = 8'd5;
        pulse_trig();
        tick(2);
        acq_enable = 1'b0;
        tick(1);
        chk("t5_busy_delay", {31'd0, d0_busy}, 32'd0);
        chk("t5_hold_delay", {31'd0, d0_hold}, 32'd0);
        pulse_trig();
        chk("t5_tc_gated", {28'd0, d0_tc}, 32'd5);
        chk("t5_lc_gated", {29'd0, d0_lc}, 32'd7);
        acq_enable = 1'b1;
        hold_delay = 8'd0;
        pulse_trig();
        tick(1);
        chk("t5_hold_up", {31'd0, d0_hold}, 32'd1);
        acq_enable = 1'b0;
        tick(1);
        chk("t5_hold_abort", {31'd0, d0_hold}, 32'd0);
        chk("t5_req_abort",  {31'd0, d0_req},  32'd0);
        chk("t5_busy_abort", {31'd0, d0_busy}, 32'd0);
        acq_enable = 1'b1;
        tick(2);

        // trigger counter wrap
        repeat (12) begin
            pulse_trig();
            tick(1);
            readout_done = 1'b1;
            tick(1);
            readout_done = 1'b0;
            tick(17);
        end
        chk("t5_tc_wrap", {28'd0, d0_tc}, 32'd2);

        // clear beats same-cycle increment, then async reset mid-readout
        trig_en_i = 1'b1;
        clr_counters = 1'b1;
        tick(1);
        trig_en_i = 1'b0;
        clr_counters = 1'b0;
        chk("t6_tc_clr",    {28'd0, d0_tc}, 32'd0);
        chk("t6_lc_clr",    {29'd0, d0_lc}, 32'd0);
        chk("t6_d1_tc_clr", d1_tc,          32'd0);
        tick(1);
        chk("t6_hold_up", {31'd0, d0_hold}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_hold", {31'd0, d0_hold}, 32'd0);
        chk("t6_rst_req",  {31'd0, d0_req},  32'd0);
        chk("t6_rst_busy", {31'd0, d0_busy}, 32'd0);
        chk("t6_rst_d1",   {31'd0, d1_hold}, 32'd0);
        #2;
        reset_n = 1'b1;
        tick(2);
        chk("t6_idle", {31'd0, d0_busy}, 32'd0);

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
